// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto a 4-bit ALU and holds the 5-bit result until it is accepted.
// Round-robin by default. Defining ALU_ARB_FIXED_PRIO_EN gives requester 0 fixed priority.
module alu_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic [1:0] op0,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   input  logic [1:0] op1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [4:0] rsp_result,
   input  logic       rsp_ready,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       take;
   logic       win;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [1:0] op_q;
   logic       id_q;
   logic [4:0] alu_res;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = EXEC;
               take      = 1'b1;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign win = ~req0;
`else
   // last_gnt resets to 1 so requester 0 wins the first contention.
   logic last_gnt;

   assign win = (req0 && req1) ? ~last_gnt : ~req0;

   always_ff @(posedge clk) begin
      if (!rst_n)    last_gnt <= 1'b1;
      else if (take) last_gnt <= win;
   end
`endif

   always_comb begin
      alu_res = '0;
      case (op_q)
         2'b00:   alu_res = {1'b0, a_q} + {1'b0, b_q};
         2'b01:   alu_res = {1'b0, a_q} - {1'b0, b_q};
         2'b10:   alu_res = {1'b0, a_q & b_q};
         default: alu_res = {1'b0, a_q | b_q};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         id_q       <= 1'b0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         rsp_result <= '0;
         rsp_id     <= 1'b0;
      end else begin
         // Grant is a one-cycle pulse covering the EXEC cycle.
         gnt0 <= take & ~win;
         gnt1 <= take & win;
         if (take) begin
            a_q  <= win ? a1  : a0;
            b_q  <= win ? b1  : b0;
            op_q <= win ? op1 : op0;
            id_q <= win;
         end
         if (state == EXEC) begin
            rsp_result <= alu_res;
            rsp_id     <= id_q;
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected {id,result} queued at stimulus, compared at each response handshake.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic [1:0] op0, op1;
   logic       gnt0, gnt1;
   logic       rsp_valid;
   logic       rsp_id;
   logic [4:0] rsp_result;
   logic       rsp_ready;
   logic       busy;

   int         tests = 0;
   int         fails = 0;
   int         model_last = 1;
   logic [5:0] sb_q[$];
   logic [5:0] mon_ent;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .req1       (req1),
      .a0         (a0),
      .b0         (b0),
      .op0        (op0),
      .a1         (a1),
      .b1         (b1),
      .op1        (op1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_ready  (rsp_ready),
      .busy       (busy)
   );

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      if (obs != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int alu_model(input int a, input int b, input int op);
      case (op)
         0:       return a + b;
         1:       return (a - b + 32) % 32;
         2:       return a & b;
         default: return a | b;
      endcase
   endfunction

   task automatic sb_push(input int id, input int res);
      logic [5:0] ent;
      ent[5]   = id[0];
      ent[4:0] = res[4:0];
      sb_q.push_back(ent);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (gnt0 || gnt1) check("gnt_excl", int'(gnt0 & gnt1), 0);
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               mon_ent = sb_q.pop_front();
               check("rsp_id", int'(rsp_id), int'(mon_ent[5]));
               check("rsp_result", int'(rsp_result), int'(mon_ent[4:0]));
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", int'(busy), 0);
   endtask

   task automatic wait_gnt(output int who);
      int n = 0;
      @(negedge clk);
      while (!(gnt0 || gnt1) && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("gnt_wait", int'(gnt0 || gnt1), 1);
      who = gnt1 ? 1 : 0;
   endtask

   task automatic run_txn(input int id, input int a, input int b, input int op);
      @(posedge clk); #1;
      if (id == 0) begin
         req0 = 1'b1; a0 = 4'(a); b0 = 4'(b); op0 = 2'(op);
      end else begin
         req1 = 1'b1; a1 = 4'(a); b1 = 4'(b); op1 = 2'(op);
      end
      sb_push(id, alu_model(a, b, op));
      model_last = id;
      // Sampling edge, then grant must be visible one cycle later.
      @(posedge clk);
      @(negedge clk);
      check("gnt0_after_sample", int'(gnt0), int'(id == 0));
      check("gnt1_after_sample", int'(gnt1), int'(id == 1));
      check("busy_exec", int'(busy), 1);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      check("gnt_one_cycle", int'(gnt0 | gnt1), 0);
      check("rsp_valid_n2", int'(rsp_valid), 1);
      wait_idle();
   endtask

   initial begin
      int who;
      int win;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; op0 = '0;
      a1 = '0; b1 = '0; op1 = '0;
      rsp_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt0", int'(gnt0), 0);
      check("rst_gnt1", int'(gnt1), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_rsp_id", int'(rsp_id), 0);
      check("rst_rsp_result", int'(rsp_result), 0);
      check("rst_busy", int'(busy), 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // rsp_ready high with nothing pending must not move the FSM.
      repeat (2) @(negedge clk);
      check("idle_ready_busy", int'(busy), 0);
      check("idle_ready_valid", int'(rsp_valid), 0);

      run_txn(0, 5, 3, 0);
      run_txn(1, 3, 5, 1);
      run_txn(1, 5, 3, 1);
      run_txn(0, 12, 10, 2);
      run_txn(0, 12, 10, 3);

      // Backpressure: result held, new req1 ignored until the handshake.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req0 = 1'b1; a0 = 4'd7; b0 = 4'd6; op0 = 2'd0;
      sb_push(0, alu_model(7, 6, 0));
      @(posedge clk);
      @(negedge clk);
      check("bp_gnt0", int'(gnt0), 1);
      req0 = 1'b0;
      @(posedge clk); #1;
      req1 = 1'b1; a1 = 4'd15; b1 = 4'd1; op1 = 2'd2;
      sb_push(1, alu_model(15, 1, 2));
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", int'(rsp_valid), 1);
         check("bp_result", int'(rsp_result), 13);
         check("bp_id", int'(rsp_id), 0);
         check("bp_busy", int'(busy), 1);
         check("bp_no_gnt1", int'(gnt1), 0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      wait_gnt(who);
      check("bp_late_gnt1", who, 1);
      req1 = 1'b0;
      wait_idle();

      // Reset during EXEC drops the transaction and restores last_gnt.
      @(posedge clk); #1;
      req0 = 1'b1; a0 = 4'd1; b0 = 4'd1; op0 = 2'd0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      req0 = 1'b0;
      @(negedge clk);
      check("pre_rst_gnt0", int'(gnt0), 1);
      @(negedge clk);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_valid", int'(rsp_valid), 0);
      check("mid_rst_gnt0", int'(gnt0), 0);
      check("mid_rst_gnt1", int'(gnt1), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      model_last = 1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_no_rsp", int'(rsp_valid), 0);
      end

      // Contention with both requests held for four transactions.
      @(posedge clk); #1;
      req0 = 1'b1; a0 = 4'd9; b0 = 4'd4; op0 = 2'd0;
      req1 = 1'b1; a1 = 4'd2; b1 = 4'd7; op1 = 2'd1;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(who);
`ifdef ALU_ARB_FIXED_PRIO_EN
         win = 0;
`else
         win = (model_last == 1) ? 0 : 1;
`endif
         model_last = win;
         check("arb_order", who, win);
         if (win == 0) sb_push(0, alu_model(9, 4, 0));
         else          sb_push(1, alu_model(2, 7, 1));
      end
      req0 = 1'b0;
      req1 = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      check("sb_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
